// File: rtl/rst_seq_ctrl.sv
// Reset controller: POR synchroniser, maskable request stretching, ordered domain release, sticky cause.
// Optional RST_SEQ_CTRL_HOLD_EN adds HOLD_LAST to hold back release of the final domain.
module rst_seq_ctrl #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned SEQ_GAP        = 4
) (
    input  logic                   CLKIN,
    input  logic                   nSRSTIN,
    input  logic [NUM_REQ-1:0]     RSTREQ,
    input  logic [NUM_REQ-1:0]     RSTREQ_MASK,
`ifdef RST_SEQ_CTRL_HOLD_EN
    input  logic                   HOLD_LAST,
`endif
    input  logic                   CAUSE_CLR,
    output logic                   PORESETn,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESETn,
    output logic [NUM_REQ:0]       RESET_CAUSE,
    output logic                   RST_BUSY
);

    localparam int unsigned MAX_CNT = (STRETCH_CYCLES > SEQ_GAP) ? STRETCH_CYCLES : SEQ_GAP;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(SEQ_GAP - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0]   dom_q, dom_d;
    logic                     busy_q, busy_d;
    logic [NUM_REQ:0]         cause_q, cause_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     por_q;
    logic [NUM_REQ-1:0]       req_eff;
    logic                     req_act;
    logic                     hold_last;
    logic [NUM_DOMAINS-1:0]   dom_next;

`ifdef RST_SEQ_CTRL_HOLD_EN
    assign hold_last = HOLD_LAST;
`else
    assign hold_last = 1'b0;
`endif

    assign por_q   = sync_q[SYNC_STAGES-1];
    assign req_eff = RSTREQ & ~RSTREQ_MASK;
    assign req_act = |req_eff;

    // Domains release as a thermometer code; all-ones after the shift means the last one is going.
    assign dom_next = (dom_q << 1) | NUM_DOMAINS'(1);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        cause_d = (CAUSE_CLR ? '0 : cause_q) | {1'b0, req_eff};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        busy_d  = busy_q;
        case (state_q)
            ST_ASSERT: begin
                dom_d  = '0;
                busy_d = 1'b1;
                if (!por_q || req_act) begin
                    cnt_d = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    cnt_d = '0;
                    dom_d = NUM_DOMAINS'(1);
                    if (&dom_d) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (req_act) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    dom_d   = '0;
                    busy_d  = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    // Holding saturates the counter so release follows HOLD_LAST falling directly.
                    if (!(&dom_next && hold_last)) begin
                        cnt_d = '0;
                        dom_d = dom_next;
                        if (&dom_next) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (req_act) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    dom_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                dom_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLKIN or negedge nSRSTIN) begin
        if (!nSRSTIN) begin
            sync_q  <= '0;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            dom_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= {1'b1, {NUM_REQ{1'b0}}};
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign PORESETn      = por_q;
    assign DOMAIN_RESETn = dom_q;
    assign RESET_CAUSE   = cause_q;
    assign RST_BUSY      = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters: vector table plus async-reset sequences.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       nsrst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       clr;
    logic       por;
    logic [2:0] dom;
    logic [4:0] cause;
    logic       busy;
`ifdef RST_SEQ_CTRL_HOLD_EN
    logic       hold;
`endif

    int total = 0;
    int bad   = 0;
    int cur_edge = 0;

    rst_seq_ctrl #(
        .NUM_REQ(4),
        .NUM_DOMAINS(3),
        .SYNC_STAGES(3),
        .STRETCH_CYCLES(16),
        .SEQ_GAP(4)
    ) dut (
        .CLKIN(clk),
        .nSRSTIN(nsrst),
        .RSTREQ(req),
        .RSTREQ_MASK(mask),
`ifdef RST_SEQ_CTRL_HOLD_EN
        .HOLD_LAST(hold),
`endif
        .CAUSE_CLR(clr),
        .PORESETn(por),
        .DOMAIN_RESETn(dom),
        .RESET_CAUSE(cause),
        .RST_BUSY(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         e;
        logic [3:0] req;
        logic [3:0] mask;
        logic       clr;
        logic       por;
        logic [2:0] dom;
        logic       busy;
        logic [4:0] cause;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        cur_edge++;
        #1;
    endtask

    task automatic chk(input string name, input int e, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, got, exp);
        end
    endtask

    task automatic chk_all(input int e, input logic xpor, input logic [2:0] xdom,
                           input logic xbusy, input logic [4:0] xcause);
        chk("PORESETn", e, 32'(por), 32'(xpor));
        chk("DOMAIN_RESETn", e, 32'(dom), 32'(xdom));
        chk("RST_BUSY", e, 32'(busy), 32'(xbusy));
        chk("RESET_CAUSE", e, 32'(cause), 32'(xcause));
    endtask

    initial begin
        //               edge req      mask     clr  por  dom     busy cause
        tbl.push_back('{   2, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b000, 1'b1, 5'b10000});
        tbl.push_back('{   3, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10000});
        tbl.push_back('{  18, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10000});
        tbl.push_back('{  19, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 5'b10000});
        tbl.push_back('{  22, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 5'b10000});
        tbl.push_back('{  23, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b011, 1'b1, 5'b10000});
        tbl.push_back('{  26, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b011, 1'b1, 5'b10000});
        tbl.push_back('{  27, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 5'b10000});
        tbl.push_back('{ 100, 4'b0100, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10100});
        tbl.push_back('{ 101, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10100});
        tbl.push_back('{ 115, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10100});
        tbl.push_back('{ 116, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 5'b10100});
        tbl.push_back('{ 118, 4'b0001, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10101});
        tbl.push_back('{ 119, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10101});
        tbl.push_back('{ 133, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b10101});
        tbl.push_back('{ 134, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 5'b10101});
        tbl.push_back('{ 138, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b011, 1'b1, 5'b10101});
        tbl.push_back('{ 142, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 5'b10101});
        tbl.push_back('{ 150, 4'b0010, 4'b0010, 1'b0, 1'b1, 3'b111, 1'b0, 5'b10101});
        tbl.push_back('{ 199, 4'b0010, 4'b0010, 1'b0, 1'b1, 3'b111, 1'b0, 5'b10101});
        tbl.push_back('{ 200, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 5'b10101});
        tbl.push_back('{ 210, 4'b1000, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1, 5'b01000});
        tbl.push_back('{ 211, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b01000});
        tbl.push_back('{ 215, 4'b0000, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1, 5'b00000});
        tbl.push_back('{ 216, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b00000});
        tbl.push_back('{ 220, 4'b0001, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b00001});
        tbl.push_back('{ 221, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b00001});
        tbl.push_back('{ 235, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 5'b00001});
        tbl.push_back('{ 236, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 5'b00001});

        nsrst = 1'b0;
        req   = '0;
        mask  = '0;
        clr   = 1'b0;
`ifdef RST_SEQ_CTRL_HOLD_EN
        hold  = 1'b0;
`endif
        repeat (5) tick();
        chk_all(0, 1'b0, 3'b000, 1'b1, 5'b10000);

        #3;
        nsrst    = 1'b1;
        cur_edge = 0;

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            while (cur_edge < tbl[i].e - 1) tick();
            req  = tbl[i].req;
            mask = tbl[i].mask;
            clr  = tbl[i].clr;
            tick();
            chk_all(cur_edge, tbl[i].por, tbl[i].dom, tbl[i].busy, tbl[i].cause);
        end

        // Asynchronous reset between edges while domain 0 is out and the sequence is in progress.
        tick();
        chk("DOMAIN_RESETn", cur_edge, 32'(dom), 32'(3'b001));
        #3;
        nsrst = 1'b0;
        #1;
        chk_all(-1, 1'b0, 3'b000, 1'b1, 5'b10000);
        tick();
        tick();
        chk_all(-1, 1'b0, 3'b000, 1'b1, 5'b10000);

        // Restart with a request held across the synchroniser window and a few edges beyond.
        #3;
        nsrst    = 1'b1;
        req      = 4'b0010;
        cur_edge = 0;
        tick();
        chk("PORESETn", cur_edge, 32'(por), 32'(1'b0));
        tick();
        chk("PORESETn", cur_edge, 32'(por), 32'(1'b0));
        tick();
        chk_all(cur_edge, 1'b1, 3'b000, 1'b1, 5'b10010);
        tick();
        tick();
        req = 4'b0000;
        while (cur_edge < 20) tick();
        chk_all(cur_edge, 1'b1, 3'b000, 1'b1, 5'b10010);
        tick();
        chk_all(cur_edge, 1'b1, 3'b001, 1'b1, 5'b10010);
        while (cur_edge < 25) tick();
        chk("DOMAIN_RESETn", cur_edge, 32'(dom), 32'(3'b011));
        while (cur_edge < 28) tick();
        chk("RST_BUSY", cur_edge, 32'(busy), 32'(1'b1));
        tick();
        chk_all(cur_edge, 1'b1, 3'b111, 1'b0, 5'b10010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
